// File: rtl/expander_graph_pkg.sv
// Shared types for the expander-graph encoding stage: scheduler states,
// the edge record carried to the datapath and the output buffer depth.
package expander_graph_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_INIT = 2'd1,
        DMA_EXEC = 2'd2,
        DMA_DONE = 2'd3
    } expander_graph_state_e;

    localparam int EG_OUT_FIFO_DEPTH = 2;
    localparam int EG_IDX_W          = 20;
    localparam int EG_ROWS_W         = 16;

    // One edge as seen by the datapath. Field widths follow the package
    // constants, which match the scheduler's default parameters.
    typedef struct packed {
        logic [EG_IDX_W-1:0]  idx;
        logic [EG_ROWS_W-1:0] row;
        logic                 first;
        logic                 last;
    } eg_edge_t;

    // A new read may be issued only if every edge already committed
    // (buffered plus in flight, minus the one leaving this cycle) still
    // leaves room in the output FIFO when the read data comes back.
    function automatic logic eg_can_issue(input logic [1:0] fifo_count,
                                          input logic       inflight,
                                          input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, fifo_count} + {2'b00, inflight};
        return (occ < (3'd2 + {2'b00, pop}));
    endfunction

endpackage

// File: rtl/expander_graph_edge_fifo.sv
// Two-entry output buffer of edge records. Push and pop may happen in the
// same cycle, including when full; the head entry is held in a register so
// the datapath view stays stable while it stalls.
module expander_graph_edge_fifo
    import expander_graph_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  eg_edge_t   push_data_i,
    input  logic       pop_i,
    output eg_edge_t   head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    eg_edge_t   mem_r [EG_OUT_FIFO_DEPTH];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Qualify push/pop against current occupancy; a push into a full
    // buffer is only taken when the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop_i && (count_r != 2'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push_i && ((count_r != 2'd2) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_o  = mem_r[rd_ptr_r];
    assign valid_o = (count_r != 2'd0);
    assign count_o = count_r;

endmodule

// File: rtl/expander_graph_edge_sched.sv
// Edge scheduler: on start, walks the edge list row by row, reads each
// neighbour index from edge memory and streams it, tagged with its row and
// first/last markers, to the encoding datapath at up to one edge per cycle.
module expander_graph_edge_sched
    import expander_graph_pkg::*;
#(
    parameter int ROWS_W = EG_ROWS_W,
    parameter int DEG_W  = 6,
    parameter int IDX_W  = EG_IDX_W,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ROWS_W-1:0] num_rows_i,
    input  logic [DEG_W-1:0]  degree_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              em_rd_en_o,
    output logic [ADDR_W-1:0] em_rd_addr_o,
    input  logic [IDX_W-1:0]  em_rd_data_i,
    output logic              dp_valid_o,
    input  logic              dp_ready_i,
    output logic [IDX_W-1:0]  dp_idx_o,
    output logic [ROWS_W-1:0] dp_row_o,
    output logic              dp_first_o,
    output logic              dp_last_o
);

    expander_graph_state_e state_r;
    expander_graph_state_e state_nxt_s;

    logic [ROWS_W-1:0] rows_r;
    logic [DEG_W-1:0]  deg_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ROWS_W-1:0] row_cnt_r;
    logic [DEG_W-1:0]  edge_cnt_r;
    logic              issue_done_r;

    logic              infl_valid_r;
    logic [ROWS_W-1:0] infl_row_r;
    logic              infl_first_r;
    logic              infl_last_r;

    eg_edge_t          push_edge_s;
    eg_edge_t          head_s;
    logic              fifo_valid_s;
    logic [1:0]        fifo_count_s;
    logic              pop_s;
    logic              rd_en_s;
    logic              edge_last_s;
    logic              row_last_s;
    logic              zero_work_s;
    logic              drained_s;

    // Issue-side decode: end-of-row / end-of-list and the read strobe.
    always_comb begin
        pop_s       = fifo_valid_s && dp_ready_i;
        edge_last_s = (edge_cnt_r == (deg_r - {{(DEG_W-1){1'b0}}, 1'b1}));
        row_last_s  = (row_cnt_r == (rows_r - {{(ROWS_W-1){1'b0}}, 1'b1}));
        zero_work_s = (rows_r == {ROWS_W{1'b0}}) || (deg_r == {DEG_W{1'b0}});
        // Buffer empties this cycle: nothing arriving and at most the head leaving.
        drained_s   = !infl_valid_r && (fifo_count_s == {1'b0, pop_s});
        if ((state_r == DMA_EXEC) && !issue_done_r) begin
            rd_en_s = eg_can_issue(fifo_count_s, infl_valid_r, pop_s);
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DMA_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DMA_IDLE: begin
                if (start_i) begin
                    state_nxt_s = DMA_INIT;
                end else begin
                    state_nxt_s = DMA_IDLE;
                end
            end
            DMA_INIT: begin
                if (zero_work_s) begin
                    state_nxt_s = DMA_DONE;
                end else begin
                    state_nxt_s = DMA_EXEC;
                end
            end
            DMA_EXEC: begin
                if (issue_done_r && drained_s) begin
                    state_nxt_s = DMA_DONE;
                end else begin
                    state_nxt_s = DMA_EXEC;
                end
            end
            DMA_DONE: state_nxt_s = DMA_IDLE;
            default:  state_nxt_s = DMA_IDLE;
        endcase
    end

    // Configuration capture, row/edge counters and running read address.
    // The address simply increments per read, which yields base + r*degree + e
    // without a multiplier and wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_r       <= {ROWS_W{1'b0}};
            deg_r        <= {DEG_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            row_cnt_r    <= {ROWS_W{1'b0}};
            edge_cnt_r   <= {DEG_W{1'b0}};
            issue_done_r <= 1'b0;
        end else if ((state_r == DMA_IDLE) && start_i) begin
            rows_r <= num_rows_i;
            deg_r  <= degree_i;
            addr_r <= base_addr_i;
        end else if (state_r == DMA_INIT) begin
            row_cnt_r    <= {ROWS_W{1'b0}};
            edge_cnt_r   <= {DEG_W{1'b0}};
            issue_done_r <= 1'b0;
        end else if (rd_en_s) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (edge_last_s) begin
                edge_cnt_r <= {DEG_W{1'b0}};
                if (row_last_s) begin
                    issue_done_r <= 1'b1;
                end else begin
                    row_cnt_r <= row_cnt_r + {{(ROWS_W-1){1'b0}}, 1'b1};
                end
            end else begin
                edge_cnt_r <= edge_cnt_r + {{(DEG_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // In-flight tag register: follows the single outstanding read so its
    // tags meet the memory data one cycle later. Cleared by reset, so data
    // returning for a read cut off by reset is never pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_valid_r <= 1'b0;
            infl_row_r   <= {ROWS_W{1'b0}};
            infl_first_r <= 1'b0;
            infl_last_r  <= 1'b0;
        end else begin
            infl_valid_r <= rd_en_s;
            if (rd_en_s) begin
                infl_row_r   <= row_cnt_r;
                infl_first_r <= (edge_cnt_r == {DEG_W{1'b0}});
                infl_last_r  <= edge_last_s;
            end
        end
    end

    // Join returning data with its tags.
    always_comb begin
        push_edge_s       = '0;
        push_edge_s.idx   = em_rd_data_i;
        push_edge_s.row   = infl_row_r;
        push_edge_s.first = infl_first_r;
        push_edge_s.last  = infl_last_r;
    end

    expander_graph_edge_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_valid_r),
        .push_data_i (push_edge_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_count_s)
    );

    assign busy_o       = (state_r != DMA_IDLE);
    assign done_o       = (state_r == DMA_DONE);
    assign em_rd_en_o   = rd_en_s;
    assign em_rd_addr_o = addr_r;
    assign dp_valid_o   = fifo_valid_s;
    assign dp_idx_o     = head_s.idx;
    assign dp_row_o     = head_s.row;
    assign dp_first_o   = head_s.first;
    assign dp_last_o    = head_s.last;

endmodule

// File: tb/tb_expander_graph_edge_sched.sv
// Self-checking bench for expander_graph_edge_sched: a queue-based model of
// the expected edge stream and read addresses, a per-cycle compare process
// and directed scenarios with literal expectations.
module tb_expander_graph_edge_sched;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] num_rows_i;
    logic [5:0]  degree_i;
    logic [23:0] base_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        em_rd_en_o;
    logic [23:0] em_rd_addr_o;
    logic [19:0] em_rd_data_i;
    logic        dp_valid_o;
    logic        dp_ready_i;
    logic [19:0] dp_idx_o;
    logic [15:0] dp_row_o;
    logic        dp_first_o;
    logic        dp_last_o;

    expander_graph_edge_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_rows_i   (num_rows_i),
        .degree_i     (degree_i),
        .base_addr_i  (base_addr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .em_rd_en_o   (em_rd_en_o),
        .em_rd_addr_o (em_rd_addr_o),
        .em_rd_data_i (em_rd_data_i),
        .dp_valid_o   (dp_valid_o),
        .dp_ready_i   (dp_ready_i),
        .dp_idx_o     (dp_idx_o),
        .dp_row_o     (dp_row_o),
        .dp_first_o   (dp_first_o),
        .dp_last_o    (dp_last_o)
    );

    typedef struct {
        logic [19:0] idx;
        int          row;
        bit          first;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] addr_log[$];
    int          row_log[$];
    bit          first_log[$];
    bit          last_log[$];
    logic [19:0] idx_log[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int rel = 0;
    bit mon_en = 0;
    bit rnd_ready = 0;
    int n_total, n_issued, n_accepted;
    int done_rel, first_rd, first_valid;
    logic [23:0] cfg_base;
    bit          prev_stall;
    logic [38:0] prev_bus;
    logic        rd_seen = 1'b0;
    logic [23:0] rd_addr_seen = 24'h0;

    // Edge memory contents as a function of address.
    function automatic logic [19:0] memf(input logic [23:0] a);
        return a[19:0] ^ 20'hA5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory and ready driver: read data valid the cycle after the strobe.
    initial begin
        em_rd_data_i = 20'h0;
        dp_ready_i   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            em_rd_data_i = rd_seen ? memf(rd_addr_seen) : 20'h0;
            dp_ready_i   = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Compare process: checks DUT outputs against the model every cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [23:0] ea;
        rd_seen      <= em_rd_en_o;
        rd_addr_seen <= em_rd_addr_o;
        if (mon_en) begin
            rel = cyc - t0;
            if (rel == 1) chk("busy_in_init", busy_o, 1);
            if (em_rd_en_o) begin
                ea = cfg_base + n_issued[23:0];
                chk("rd_addr", em_rd_addr_o, ea);
                chk("rd_not_extra", n_issued < n_total, 1);
                addr_log.push_back(em_rd_addr_o);
                if (first_rd < 0) first_rd = rel;
                n_issued++;
            end
            if (dp_valid_o && first_valid < 0) first_valid = rel;
            if (prev_stall)
                chk("stall_hold", {dp_valid_o, dp_idx_o, dp_row_o, dp_first_o, dp_last_o}, prev_bus);
            if (dp_valid_o && dp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("dp_extra_edge", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dp_idx", dp_idx_o, e.idx);
                    chk("dp_row", dp_row_o, e.row);
                    chk("dp_first", dp_first_o, e.first);
                    chk("dp_last", dp_last_o, e.last);
                end
                idx_log.push_back(dp_idx_o);
                row_log.push_back(dp_row_o);
                first_log.push_back(dp_first_o);
                last_log.push_back(dp_last_o);
                n_accepted++;
            end
            if (!dp_ready_i) chk("buffer_bound", (n_issued - n_accepted) <= 3, 1);
            prev_stall = dp_valid_o && !dp_ready_i;
            prev_bus   = {dp_valid_o, dp_idx_o, dp_row_o, dp_first_o, dp_last_o};
            if (done_o) begin
                if (done_rel < 0) done_rel = rel;
                else chk("done_single_pulse", rel, done_rel);
            end
            if (done_rel >= 0 && rel == done_rel + 1) chk("busy_after_done", busy_o, 0);
        end
    end

    task automatic run_cfg(input int rows, input int deg, input logic [23:0] base,
                           input bit rnd, input bit repulse);
        int n;
        int guard;
        logic [23:0] a;
        n = rows * deg;
        exp_q.delete(); addr_log.delete(); row_log.delete();
        first_log.delete(); last_log.delete(); idx_log.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < deg; c++) begin
                a = base + 24'(r * deg + c);
                exp_q.push_back('{memf(a), r, (c == 0), (c == deg - 1)});
            end
        end
        cfg_base = base; n_total = n; n_issued = 0; n_accepted = 0;
        done_rel = -1; first_rd = -1; first_valid = -1; prev_stall = 0;
        rnd_ready   = rnd;
        num_rows_i  = 16'(rows);
        degree_i    = 6'(deg);
        base_addr_i = base;
        @(negedge clk);
        start_i = 1'b1;
        t0 = cyc;
        mon_en = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        guard = 0;
        while (done_rel < 0 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (repulse && (cyc - t0) == 6) begin
                start_i     = 1'b1;
                num_rows_i  = 16'd7;
                degree_i    = 6'd2;
                base_addr_i = 24'h0;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        chk("done_seen", done_rel >= 0, 1);
        repeat (3) @(negedge clk);
        chk("model_drained", exp_q.size(), 0);
        chk("reads_issued", n_issued, n);
        chk("edges_accepted", n_accepted, n);
        if (!rnd) chk("done_cycle", done_rel, (n == 0) ? 2 : 4 + n);
        chk("first_read_cycle", first_rd, (n == 0) ? -1 : 2);
        chk("first_valid_cycle", first_valid, (n == 0) ? -1 : 4);
        mon_en = 1'b0;
        rnd_ready = 1'b0;
    endtask

    task automatic chk_rows_3x4;
        int exp_rows[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        chk("log_len_3x4", row_log.size(), 12);
        if (row_log.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("row_seq_3x4", row_log[i], exp_rows[i]);
                chk("first_seq_3x4", first_log[i], (i % 4) == 0);
                chk("last_seq_3x4", last_log[i], (i % 4) == 3);
            end
        end
    endtask

    initial begin
        logic [23:0] wrap_addrs[4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        rst = 1'b1; start_i = 1'b0;
        num_rows_i = 16'd0; degree_i = 6'd0; base_addr_i = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, em_rd_en_o, dp_valid_o, dp_first_o, dp_last_o,
                              em_rd_addr_o, dp_idx_o, dp_row_o}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 3 rows x degree 4, always ready
        run_cfg(3, 4, 24'h100, 0, 0);
        chk("addr_count_3x4", addr_log.size(), 12);
        if (addr_log.size() == 12) begin
            chk("addr_first_3x4", addr_log[0], 24'h100);
            chk("addr_last_3x4", addr_log[11], 24'h10B);
            chk("idx_first_3x4", idx_log[0], 20'hA5B5A);
        end
        chk_rows_3x4();

        // same with random back-pressure
        run_cfg(3, 4, 24'h100, 1, 0);
        chk_rows_3x4();

        // zero-work starts
        run_cfg(3, 0, 24'h100, 0, 0);
        run_cfg(0, 4, 24'h100, 0, 0);

        // address wrap-around
        run_cfg(1, 4, 24'hFFFFFE, 0, 0);
        chk("addr_count_wrap", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("addr_wrap", addr_log[i], wrap_addrs[i]);
        end

        // start re-pulsed during EXEC must be ignored
        run_cfg(3, 4, 24'h100, 0, 1);
        chk_rows_3x4();

        // asynchronous reset mid-EXEC
        num_rows_i = 16'd3; degree_i = 6'd4; base_addr_i = 24'h100;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_before_reset", busy_o, 1);
        chk("streaming_before_reset", dp_valid_o, 1);
        #2 rst = 1'b1;
        #1 chk("reset_async_outputs", {busy_o, done_o, em_rd_en_o, dp_valid_o, dp_first_o, dp_last_o,
                                        em_rd_addr_o, dp_idx_o, dp_row_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_late_push_after_reset", {busy_o, dp_valid_o}, 0);
        run_cfg(3, 4, 24'h200, 0, 0);
        chk_rows_3x4();

        // degree 1: every edge is both first and last
        run_cfg(5, 1, 24'h40, 0, 0);
        chk("log_len_deg1", row_log.size(), 5);
        if (row_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("row_deg1", row_log[i], i);
                chk("first_last_deg1", {first_log[i], last_log[i]}, 2'b11);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expander_graph_edge_sched.md
# expander_graph_edge_sched

Edge scheduler for the expander-graph encoding stage. After a start pulse it walks the graph's edge list in the edge memory, row by row. For each edge it fetches the neighbour index and presents it, tagged with row and first/last markers, to the encoding datapath over a valid/ready stream. It sits between the top-level control (start/done) and the expander datapath, and sustains one edge per cycle when the datapath is not stalling.

## Interface
Parameters:
- ROWS_W, 16, width of row count and row tag
- DEG_W, 6, width of per-row degree
- IDX_W, 20, width of neighbour index stored in edge memory
- ADDR_W, 24, edge memory address width

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle start request; honoured only in DMA_IDLE
- num_rows_i  in  ROWS_W  number of output rows; sampled on accepted start
- degree_i  in  DEG_W  edges per row; sampled on accepted start
- base_addr_i  in  ADDR_W  edge-list base address; sampled on accepted start
- busy_o  out  1  high in any state other than DMA_IDLE
- done_o  out  1  one-cycle pulse in DMA_DONE
- em_rd_en_o  out  1  edge memory read strobe
- em_rd_addr_o  out  ADDR_W  edge memory read address
- em_rd_data_i  in  IDX_W  read data, valid exactly 1 cycle after em_rd_en_o
- dp_valid_o  out  1  edge available to datapath
- dp_ready_i  in  1  datapath accepts edge
- dp_idx_o  out  IDX_W  neighbour index
- dp_row_o  out  ROWS_W  row the edge belongs to
- dp_first_o / dp_last_o  out  1 each  first / last edge of its row

## Operation
- FSM uses expander_graph_state_e:
  - DMA_IDLE -> DMA_INIT on start_i.
  - DMA_INIT (1 cycle):
    - latches parameters and clears counters.
    - If num_rows or degree is 0 -> DMA_DONE; else -> DMA_EXEC.
  - DMA_EXEC -> DMA_DONE once every edge is issued, no read is in flight, and the FIFO is empty.
  - DMA_DONE -> DMA_IDLE after 1 cycle.
- start_i outside DMA_IDLE is ignored.
- Addressing:
  - A running address starts at base_addr and increments by 1 per issued read, so the address for row r, edge e is base + r*degree + e.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is legal and not flagged.
  - No multiplier.
- Issue counters: edge e wraps at degree-1 and then increments row r. Issuing stops after (num_rows-1, degree-1).
- Tags (row, first = e==0, last = e==degree-1) travel in a 1-deep in-flight register alongside the read. They join the returning data into a 2-entry output FIFO.
- Read issue rule: em_rd_en_o = EXEC && edges remain && (fifo_count + inflight − pop) < 2, where pop = dp_valid_o && dp_ready_i.
- FIFO output drives dp_*.
  - dp_* must hold stable while dp_valid_o && !dp_ready_i.
  - Edges are delivered in issue order with no loss or duplication.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays unchanged.
- degree = 1: every edge has first = last = 1.

## Timing
- Reset values: busy_o, done_o, em_rd_en_o, dp_valid_o, dp_first_o, dp_last_o = 0; em_rd_addr_o, dp_idx_o, dp_row_o = 0; state DMA_IDLE; FIFO empty.
- Reset takes effect immediately (asynchronous), including mid-operation. Any in-flight read is discarded and its late em_rd_data_i is ignored.
- Start at cycle 0:
  - cycle 1: DMA_INIT, busy_o = 1.
  - cycle 2: first em_rd_en_o.
  - cycle 3: data returns and is written to the FIFO.
  - cycle 4: first dp_valid_o.
- With dp_ready_i held high, one edge per cycle. Last edge accepted in cycle 3 + N (N = num_rows × degree); DMA_DONE with done_o in cycle 4 + N; DMA_IDLE in 5 + N.
- Zero-work start: done_o in cycle 2, no reads, no dp_valid_o.
- dp_ready_i low: at most 2 edges buffered, and em_rd_en_o drops within 1 cycle.

## Structure
- expander_graph_pkg holds the existing expander_graph_state_e. Add a constant EG_OUT_FIFO_DEPTH = 2 and a packed struct eg_edge_t {idx, row, first, last}.
- Sub-module expander_graph_edge_fifo: 2-entry FIFO of eg_edge_t with count output and same-cycle push/pop.
- Top module: FSM, counters, address generator, in-flight tag register.

## Test plan
- num_rows = 3, degree = 4, base = 0x100, dp_ready_i = 1:
  - reads at 0x100..0x10B on consecutive cycles;
  - 12 edges with rows 0,0,0,0,1,…,2; first/last on e = 0/3;
  - done_o in cycle 16.
- Same config with dp_ready_i toggling randomly: identical edge sequence, dp_* stable while stalled, never more than 2 edges buffered.
- degree = 0 (and separately num_rows = 0): no em_rd_en_o, done_o in cycle 2, busy_o low from cycle 3.
- base = 0xFFFFFE, num_rows = 1, degree = 4: addresses FFFFFE, FFFFFF, 000000, 000001.
- start_i re-pulsed during EXEC: ignored, sequence unchanged. rst asserted mid-EXEC: all outputs 0 immediately, clean restart on the next start.
- degree = 1, num_rows = 5: five edges, each with first = last = 1, rows 0..4.
